alu_cond_flag_unit: RTL and testbench
=====================================

Name: alu_cond_flag_unit

Overview:
Stage directly downstream of the 8-bit ALU in the multi-cycle CPU datapath. It holds the ALUOut register and the architectural flag register, which is fed from the ALU's {CO,OVF,N,Z} flag bus. It evaluates 4-bit ARM-style condition codes against the stored flags and latches the result as CondEx. The registered CondEx gates PC, register-file and memory write enables, and gates its own flag updates.

Parameters:
WIDTH, 8, datapath width of ALUResult/ALUOut
FLAG_RESET, 4'b0000, reset value of Flags, ordered {C,V,N,Z}

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
ALUResult  input  WIDTH  ALU result
ALUFlags  input  4  ALU flags {C,V,N,Z} (bit3=C, bit2=V, bit1=N, bit0=Z)
ALUOutEn  input  1  load ALUOut from ALUResult
Cond  input  4  instruction condition field
CondLatch  input  1  evaluate Cond and load CondEx register (decode cycle)
FlagW  input  2  bit1: update N,Z; bit0: update C,V
PCS  input  1  instruction writes PC
RegW  input  1  instruction writes register file
MemW  input  1  instruction writes memory
NoWrite  input  1  compare-type instruction, suppresses RegWrite
ALUOut  output  WIDTH  registered ALU result
Flags  output  4  registered flags {C,V,N,Z}
CondEx  output  1  registered condition-pass bit
PCSrcG  output  1  PCS & CondEx
RegWriteG  output  1  RegW & CondEx & ~NoWrite
MemWriteG  output  1  MemW & CondEx

Behaviour:
- Clock/reset: one clock domain, clk. reset is synchronous and active-high and has priority over all loads.
- Reset values: ALUOut=0, Flags=FLAG_RESET, CondEx=0, therefore PCSrcG=RegWriteG=MemWriteG=0.
- ALUOut: loads ALUResult on a clk edge when ALUOutEn=1, else holds. Latency 1 cycle.
- Flags:
  - On a clk edge, if CondEx=1 (the current registered value) and FlagW[1]=1: Flags[1:0] <= ALUFlags[1:0].
  - If CondEx=1 and FlagW[0]=1: Flags[3:2] <= ALUFlags[3:2].
  - Otherwise each half holds. FlagW has no effect when CondEx=0.
- CondEx: on a clk edge with CondLatch=1, CondEx <= eval(Cond, Flags); else holds.
- eval (flags C,V,N,Z):
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1 (treated as always)
- Gated outputs: combinational from the registered CondEx and live PCS/RegW/MemW/NoWrite; no extra latency.
- Simultaneous CondLatch and FlagW in one cycle:
  - CondEx evaluates the pre-update Flags.
  - The flag update is gated by the old CondEx.
  - Both registers load on the same edge.
- Reset asserted mid-instruction: all state clears on that edge and all gated writes drop to 0 in the following cycle. No pending update survives.
- ALUOutEn and FlagW are independent and may be asserted together.

Optional Feature:
FLAG_FWD_EN
- Defined: when CondLatch and a qualified flag write (CondEx=1, FlagW!=0) occur in the same cycle, CondEx evaluates the forwarded next-state flags (updated halves taken from ALUFlags, other halves from Flags).
- Undefined: CondEx always evaluates the registered Flags, per Behaviour.

Test Plan:
1. Reset for 2 cycles with all inputs at 1 -> ALUOut=8'h00, Flags=4'b0000, CondEx=0, RegWriteG=MemWriteG=PCSrcG=0.
2. CondLatch=1, Cond=4'hE -> CondEx=1 next cycle. Then ALUFlags=4'b0001, FlagW=2'b10 -> Flags=4'b0001. Then Cond=4'h0 latched -> CondEx=1; Cond=4'h1 latched -> CondEx=0.
3. CondEx=0, FlagW=2'b11, ALUFlags=4'b1111 -> Flags unchanged at 4'b0001. RegW=1, MemW=1 -> RegWriteG=0, MemWriteG=0.
4. CondEx=1, FlagW=2'b01, ALUFlags=4'b1000 from Flags=4'b0010 -> Flags=4'b1010 (N,Z held). Cond=4'hA -> CondEx=0 (N=1, V=0); Cond=4'hB -> 1; Cond=4'h8 -> 1.
5. ALUResult=8'hA5, ALUOutEn=1 -> ALUOut=8'hA5. Next cycle ALUOutEn=0, ALUResult=8'h3C -> ALUOut stays 8'hA5. RegW=1, NoWrite=1, CondEx=1 -> RegWriteG=0.
6. Same cycle: CondEx=1, FlagW=2'b10, ALUFlags=4'b0001, Flags=4'b0000, CondLatch=1, Cond=4'h0 -> CondEx=0 without FLAG_FWD_EN, CondEx=1 with it. Flags=4'b0001 in both builds.

Source files
------------

// File: rtl/alu_cond_flag_unit.sv
// ALUOut / flag register stage with ARM-style condition evaluation and write gating.
// Optional FLAG_FWD_EN: condition evaluation sees same-cycle qualified flag updates.
module alu_cond_flag_unit #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [3:0]       ALUFlags,
  input  logic             ALUOutEn,
  input  logic [3:0]       Cond,
  input  logic             CondLatch,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCSrcG,
  output logic             RegWriteG,
  output logic             MemWriteG
);

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  logic [3:0] flags_nxt;
  logic [3:0] eval_flags;
  logic       fc, fv, fn, fz;
  logic       pass;

  // Each half of the flag register updates only under the current registered CondEx.
  always_comb begin
    flags_nxt = Flags;
    if (CondEx && FlagW[1]) flags_nxt[1:0] = ALUFlags[1:0];
    if (CondEx && FlagW[0]) flags_nxt[3:2] = ALUFlags[3:2];
  end

`ifdef FLAG_FWD_EN
  assign eval_flags = flags_nxt;
`else
  assign eval_flags = Flags;
`endif

  assign fc = eval_flags[3];
  assign fv = eval_flags[2];
  assign fn = eval_flags[1];
  assign fz = eval_flags[0];

  always_comb begin
    pass = 1'b1;
    case (cond_e'(Cond))
      EQ:      pass = fz;
      NE:      pass = ~fz;
      CS:      pass = fc;
      CC:      pass = ~fc;
      MI:      pass = fn;
      PL:      pass = ~fn;
      VS:      pass = fv;
      VC:      pass = ~fv;
      HI:      pass = fc & ~fz;
      LS:      pass = ~fc | fz;
      GE:      pass = (fn == fv);
      LT:      pass = (fn != fv);
      GT:      pass = ~fz & (fn == fv);
      LE:      pass = fz | (fn != fv);
      default: pass = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUOut <= '0;
      Flags  <= FLAG_RESET;
      CondEx <= 1'b0;
    end else begin
      if (ALUOutEn) ALUOut <= ALUResult;
      Flags <= flags_nxt;
      if (CondLatch) CondEx <= pass;
    end
  end

  assign PCSrcG    = PCS & CondEx;
  assign RegWriteG = RegW & CondEx & ~NoWrite;
  assign MemWriteG = MemW & CondEx;

endmodule

// File: tb/tb_alu_cond_flag_unit.sv
// Scoreboard bench for alu_cond_flag_unit: directed sequence followed by random traffic.
module tb_alu_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ALUResult = '0;
  logic [3:0] ALUFlags = '0;
  logic       ALUOutEn = 1'b0;
  logic [3:0] Cond = '0;
  logic       CondLatch = 1'b0;
  logic [1:0] FlagW = '0;
  logic       PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
  logic [7:0] ALUOut;
  logic [3:0] Flags;
  logic       CondEx, PCSrcG, RegWriteG, MemWriteG;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] aluout;
    logic [3:0] flags;
    logic       condex;
  } exp_t;

  exp_t q[$];

  logic [7:0] m_aluout;
  logic [3:0] m_flags;
  logic       m_condex;

  alu_cond_flag_unit #(.WIDTH(8), .FLAG_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .ALUResult(ALUResult), .ALUFlags(ALUFlags),
    .ALUOutEn(ALUOutEn), .Cond(Cond), .CondLatch(CondLatch), .FlagW(FlagW),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .ALUOut(ALUOut), .Flags(Flags), .CondEx(CondEx),
    .PCSrcG(PCSrcG), .RegWriteG(RegWriteG), .MemWriteG(MemWriteG)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ARM pairing: even code is the base test, odd code its inverse; 14/15 always pass.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic C, V, N, Z, base;
    {C, V, N, Z} = f;
    case (c[3:1])
      3'd0: base = Z;
      3'd1: base = C;
      3'd2: base = N;
      3'd3: base = V;
      3'd4: base = C && !Z;
      3'd5: base = (N ~^ V);
      3'd6: base = !Z && (N ~^ V);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return c[0] ? !base : base;
  endfunction

  task automatic step(input logic rst, input logic latch, input logic [3:0] cnd,
                      input logic [1:0] fw, input logic [3:0] af, input logic oen,
                      input logic [7:0] res, input logic pcs, input logic rw,
                      input logic mw, input logic nw);
    exp_t e, got;
    logic [3:0] nf, ef;
    @(negedge clk);
    reset = rst; CondLatch = latch; Cond = cnd; FlagW = fw; ALUFlags = af;
    ALUOutEn = oen; ALUResult = res; PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
    if (rst) begin
      e.aluout = 8'h00; e.flags = 4'b0000; e.condex = 1'b0;
    end else begin
      nf = m_flags;
      if (m_condex && fw[1]) nf = {nf[3:2], af[1:0]};
      if (m_condex && fw[0]) nf = {af[3:2], nf[1:0]};
`ifdef FLAG_FWD_EN
      ef = nf;
`else
      ef = m_flags;
`endif
      e.aluout = oen ? res : m_aluout;
      e.flags  = nf;
      e.condex = latch ? cond_pass(cnd, ef) : m_condex;
    end
    q.push_back(e);
    m_aluout = e.aluout; m_flags = e.flags; m_condex = e.condex;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 1, 0);
    end else begin
      got = q.pop_front();
      chk("aluout", {24'b0, ALUOut}, {24'b0, got.aluout});
      chk("flags", {28'b0, Flags}, {28'b0, got.flags});
      chk("condex", {31'b0, CondEx}, {31'b0, got.condex});
      chk("pcsrcg", {31'b0, PCSrcG}, {31'b0, pcs & got.condex});
      chk("regwriteg", {31'b0, RegWriteG}, {31'b0, rw & got.condex & ~nw});
      chk("memwriteg", {31'b0, MemWriteG}, {31'b0, mw & got.condex});
    end
  endtask

  initial begin
    m_aluout = '0; m_flags = '0; m_condex = 1'b0;
    // reset with every input high
    step(1, 1, 4'hF, 2'b11, 4'hF, 1, 8'hFF, 1, 1, 1, 1);
    step(1, 1, 4'hF, 2'b11, 4'hF, 1, 8'hFF, 1, 1, 1, 1);
    chk("plan_reset_flags", {28'b0, Flags}, 32'h0);
    // always-condition, then Z update, EQ/NE
    step(0, 1, 4'hE, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 0, 4'h0, 2'b10, 4'b0001, 0, 8'h00, 0, 0, 0, 0);
    chk("plan_flags_z", {28'b0, Flags}, 32'h1);
    step(0, 1, 4'h0, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 4'h1, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    chk("plan_ne_fail", {31'b0, CondEx}, 32'h0);
    // flag write ignored while CondEx=0
    step(0, 0, 4'h0, 2'b11, 4'hF, 0, 8'h00, 0, 1, 1, 0);
    chk("plan_flags_held", {28'b0, Flags}, 32'h1);
    // C,V-only update then GE/LT/HI
    step(0, 1, 4'hE, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 0, 4'h0, 2'b11, 4'b0010, 0, 8'h00, 0, 0, 0, 0);
    step(0, 0, 4'h0, 2'b01, 4'b1000, 0, 8'h00, 0, 0, 0, 0);
    chk("plan_flags_cv", {28'b0, Flags}, 32'hA);
    step(0, 1, 4'hA, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 4'hB, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 4'h8, 2'b00, 4'h0, 0, 8'h00, 0, 0, 0, 0);
    chk("plan_hi_pass", {31'b0, CondEx}, 32'h1);
    // ALUOut load/hold, NoWrite suppression
    step(0, 0, 4'h0, 2'b00, 4'h0, 1, 8'hA5, 0, 0, 0, 0);
    step(0, 0, 4'h0, 2'b00, 4'h0, 0, 8'h3C, 1, 1, 1, 1);
    chk("plan_aluout_hold", {24'b0, ALUOut}, 32'hA5);
    // simultaneous latch and flag write
    step(0, 0, 4'h0, 2'b11, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 4'h0, 2'b10, 4'b0001, 0, 8'h00, 0, 0, 0, 0);
    chk("plan_same_flags", {28'b0, Flags}, 32'h1);
`ifdef FLAG_FWD_EN
    chk("plan_same_condex", {31'b0, CondEx}, 32'h1);
`else
    chk("plan_same_condex", {31'b0, CondEx}, 32'h0);
`endif
    // reset mid-instruction with writes pending
    step(0, 1, 4'hE, 2'b00, 4'h0, 0, 8'h00, 1, 1, 1, 0);
    step(1, 1, 4'hE, 2'b11, 4'hF, 1, 8'h77, 1, 1, 1, 0);
    step(0, 0, 4'h0, 2'b11, 4'hF, 0, 8'h00, 1, 1, 1, 0);
    chk("plan_post_reset_regw", {31'b0, RegWriteG}, 32'h0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
           8'($urandom_range(0, 255)), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1));
    end
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
